// File: rtl/max_unpool2d_pkg.sv
// Shared types and helpers for the max-unpooling block.
//   state_t     : FSM states (FILL gathers a pooled row, EMIT expands it).
//   row_entry_t : one row-buffer slot holding a pooled value and its argmax index.
//   cnt_width   : bit width for a counter over n positions (never below 1).
//   index_width : width of the in-window argmax index for a kw x kh kernel.
package max_unpool_pkg;

    typedef enum logic [0:0] {
        FILL,
        EMIT
    } state_t;

    // Entry fields are sized for the widest supported build; narrower builds
    // zero-extend on write and slice on read, so unused upper bits are constant.
    localparam int unsigned MAX_VALUE_W = 64;
    localparam int unsigned MAX_INDEX_W = 16;

    typedef struct packed {
        logic [MAX_VALUE_W-1:0] value;
        logic [MAX_INDEX_W-1:0] index;
    } row_entry_t;

    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int unsigned index_width(input int unsigned kw, input int unsigned kh);
        return cnt_width(kw * kh);
    endfunction

endpackage

// File: rtl/max_unpool2d_if.sv
// Stream bundle for max_unpool2d.
//   data_in_0 / data_in_0_index / data_in_0_valid / data_in_0_ready : pooled input stream
//   data_out_0 / data_out_0_valid / data_out_0_ready                 : unpooled output stream
// master: the side that feeds pooled pairs and consumes pixels; slave: the unpooling block.
interface max_unpool2d_if #(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned INDEX_W = 2
);
    logic [DATA_W-1:0]  data_in_0;
    logic [INDEX_W-1:0] data_in_0_index;
    logic               data_in_0_valid;
    logic               data_in_0_ready;
    logic [DATA_W-1:0]  data_out_0;
    logic               data_out_0_valid;
    logic               data_out_0_ready;

    modport master (
        output data_in_0, data_in_0_index, data_in_0_valid, data_out_0_ready,
        input  data_in_0_ready, data_out_0, data_out_0_valid
    );

    modport slave (
        input  data_in_0, data_in_0_index, data_in_0_valid, data_out_0_ready,
        output data_in_0_ready, data_out_0, data_out_0_valid
    );
endinterface

// File: rtl/max_unpool2d_row_buffer.sv
// One pooled row of (value, index) pairs.
//   clk, rst         : clock, asynchronous active-high reset (clears all entries)
//   wr_en, wr_col    : write strobe and column
//   wr_value/index   : entry written at wr_col
//   rd_col           : combinational read column
//   rd_value/index   : entry stored at rd_col
module unpool_row_buffer
    import max_unpool_pkg::*;
#(
    parameter int unsigned DEPTH   = 2,
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned INDEX_W = 2,
    parameter int unsigned COL_W   = cnt_width(DEPTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_en,
    input  logic [COL_W-1:0]   wr_col,
    input  logic [DATA_W-1:0]  wr_value,
    input  logic [INDEX_W-1:0] wr_index,
    input  logic [COL_W-1:0]   rd_col,
    output logic [DATA_W-1:0]  rd_value,
    output logic [INDEX_W-1:0] rd_index
);

    row_entry_t mem_q [DEPTH];
    row_entry_t wr_entry;
    row_entry_t rd_entry;

    assign wr_entry = '{value: MAX_VALUE_W'(wr_value), index: MAX_INDEX_W'(wr_index)};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en) begin
            mem_q[wr_col] <= wr_entry;
        end
    end

    assign rd_entry = mem_q[rd_col];
    assign rd_value = rd_entry.value[DATA_W-1:0];
    assign rd_index = rd_entry.index[INDEX_W-1:0];

    // Upper entry bits are always zero in this build.
    logic unused_rd_bits;
    assign unused_rd_bits = ^rd_entry;

endmodule

// File: rtl/max_unpool2d.sv
// Streaming 2-D max-unpooling (stride == kernel, no padding).
// Collects one pooled row of (value, argmax) pairs, then emits the KERNEL_HEIGHT
// full-resolution rows it covers in raster order; each window holds the value at
// its argmax position and zeros elsewhere.
//   clk, rst    : clock, asynchronous active-high reset
//   bus         : slave side of max_unpool2d_if (pooled input, pixel output)
//   index_error : sticky, set when an accepted index lies outside the window
module max_unpool2d
    import max_unpool_pkg::*;
#(
    parameter int unsigned DATA_IN_0_PRECISION_0 = 8,
    parameter int unsigned DATA_IN_0_PRECISION_1 = 3,
    parameter int unsigned POOLED_WIDTH          = 2,
    parameter int unsigned POOLED_HEIGHT         = 2,
    parameter int unsigned KERNEL_WIDTH          = 2,
    parameter int unsigned KERNEL_HEIGHT         = 2
) (
    input  logic          clk,
    input  logic          rst,
    max_unpool2d_if.slave bus,
    output logic          index_error
);

    localparam int unsigned WINDOW = KERNEL_WIDTH * KERNEL_HEIGHT;
    localparam int unsigned IDX_W  = index_width(KERNEL_WIDTH, KERNEL_HEIGHT);
    localparam int unsigned COL_W  = cnt_width(POOLED_WIDTH);
    localparam int unsigned KX_W   = cnt_width(KERNEL_WIDTH);
    localparam int unsigned KY_W   = cnt_width(KERNEL_HEIGHT);
    localparam int unsigned ROW_W  = cnt_width(POOLED_HEIGHT);

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(POOLED_WIDTH - 1);
    localparam logic [KX_W-1:0]  KX_LAST  = KX_W'(KERNEL_WIDTH - 1);
    localparam logic [KY_W-1:0]  KY_LAST  = KY_W'(KERNEL_HEIGHT - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(POOLED_HEIGHT - 1);

    // Fractional bits only travel with the data; nothing here depends on them.
    localparam int unsigned unused_frac_w = DATA_IN_0_PRECISION_1;

    state_t             state_q, state_d;
    logic [COL_W-1:0]   in_col_q, in_col_d;
    logic [COL_W-1:0]   pc_q, pc_d;
    logic [KX_W-1:0]    kx_q, kx_d;
    logic [KY_W-1:0]    ky_q, ky_d;
    logic [ROW_W-1:0]   prow_q, prow_d;
    logic               index_error_q, index_error_d;

    logic                             accept;
    logic                             fire;
    logic                             hit;
    logic [DATA_IN_0_PRECISION_0-1:0] rd_value;
    logic [IDX_W-1:0]                 rd_index;
    int unsigned                      win_pos;

    unpool_row_buffer #(
        .DEPTH   (POOLED_WIDTH),
        .DATA_W  (DATA_IN_0_PRECISION_0),
        .INDEX_W (IDX_W),
        .COL_W   (COL_W)
    ) u_row_buffer (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (accept),
        .wr_col   (in_col_q),
        .wr_value (bus.data_in_0),
        .wr_index (bus.data_in_0_index),
        .rd_col   (pc_q),
        .rd_value (rd_value),
        .rd_index (rd_index)
    );

    assign accept = bus.data_in_0_valid && bus.data_in_0_ready;
    assign fire   = bus.data_out_0_valid && bus.data_out_0_ready;

    // An out-of-range index can never equal win_pos, so its window is all zeros.
    assign win_pos = 32'(ky_q) * KERNEL_WIDTH + 32'(kx_q);
    assign hit     = (32'(rd_index) == win_pos);

    assign index_error = index_error_q;

    always_comb begin
        bus.data_in_0_ready  = 1'b0;
        bus.data_out_0_valid = 1'b0;
        bus.data_out_0       = '0;
        // Ready is masked by rst so nothing is taken while reset is held.
        if (state_q == FILL && !rst) begin
            bus.data_in_0_ready = 1'b1;
        end
        if (state_q == EMIT) begin
            bus.data_out_0_valid = 1'b1;
            if (hit) begin
                bus.data_out_0 = rd_value;
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        in_col_d      = in_col_q;
        pc_d          = pc_q;
        kx_d          = kx_q;
        ky_d          = ky_q;
        prow_d        = prow_q;
        index_error_d = index_error_q;

        if (accept && (32'(bus.data_in_0_index) >= WINDOW)) begin
            index_error_d = 1'b1;
        end

        unique case (state_q)
            FILL: begin
                if (accept) begin
                    if (in_col_q == COL_LAST) begin
                        in_col_d = '0;
                        state_d  = EMIT;
                    end else begin
                        in_col_d = in_col_q + 1'b1;
                    end
                end
            end
            EMIT: begin
                // ox walks as (pc, kx); ky selects the row inside the window.
                if (fire) begin
                    if (kx_q == KX_LAST) begin
                        kx_d = '0;
                        if (pc_q == COL_LAST) begin
                            pc_d = '0;
                            if (ky_q == KY_LAST) begin
                                ky_d    = '0;
                                state_d = FILL;
                                prow_d  = (prow_q == ROW_LAST) ? '0 : prow_q + 1'b1;
                            end else begin
                                ky_d = ky_q + 1'b1;
                            end
                        end else begin
                            pc_d = pc_q + 1'b1;
                        end
                    end else begin
                        kx_d = kx_q + 1'b1;
                    end
                end
            end
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= FILL;
            in_col_q      <= '0;
            pc_q          <= '0;
            kx_q          <= '0;
            ky_q          <= '0;
            prow_q        <= '0;
            index_error_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            in_col_q      <= in_col_d;
            pc_q          <= pc_d;
            kx_q          <= kx_d;
            ky_q          <= ky_d;
            prow_q        <= prow_d;
            index_error_q <= index_error_d;
        end
    end

endmodule

// File: tb/tb_max_unpool2d.sv
module tb_max_unpool2d;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // Default 2x2 kernel build and a 3x1 kernel build (index 3 out of range).
    max_unpool2d_if #(.DATA_W(8), .INDEX_W(2)) bus0 ();
    max_unpool2d_if #(.DATA_W(8), .INDEX_W(2)) bus3 ();
    logic err0;
    logic err3;

    max_unpool2d #(
        .DATA_IN_0_PRECISION_0 (8),
        .DATA_IN_0_PRECISION_1 (3),
        .POOLED_WIDTH          (2),
        .POOLED_HEIGHT         (2),
        .KERNEL_WIDTH          (2),
        .KERNEL_HEIGHT         (2)
    ) u_dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus0.slave),
        .index_error (err0)
    );

    max_unpool2d #(
        .DATA_IN_0_PRECISION_0 (8),
        .DATA_IN_0_PRECISION_1 (3),
        .POOLED_WIDTH          (2),
        .POOLED_HEIGHT         (2),
        .KERNEL_WIDTH          (3),
        .KERNEL_HEIGHT         (1)
    ) u_dut3 (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus3.slave),
        .index_error (err3)
    );

    int checks = 0;
    int errors = 0;
    int outs0  = 0;
    int outs3  = 0;
    logic [7:0] q0[$];
    logic [7:0] q3[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Output monitors: pop expected pixel on each handshake, demand zero when idle.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus0.data_out_0_valid) begin
                if (bus0.data_out_0_ready) begin
                    outs0++;
                    if (q0.size() == 0) check("dut0 extra output", 32'd1, 32'd0);
                    else check("dut0 pixel", 32'(bus0.data_out_0), 32'(q0.pop_front()));
                end
            end else begin
                check("dut0 idle zero", 32'(bus0.data_out_0), 32'd0);
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (bus3.data_out_0_valid) begin
                if (bus3.data_out_0_ready) begin
                    outs3++;
                    if (q3.size() == 0) check("dut3 extra output", 32'd1, 32'd0);
                    else check("dut3 pixel", 32'(bus3.data_out_0), 32'(q3.pop_front()));
                end
            end else begin
                check("dut3 idle zero", 32'(bus3.data_out_0), 32'd0);
            end
        end
    end

    // Reference expansion of one pooled row (2 columns) into kh rows of 2*kw pixels.
    task automatic push_row(input bit to3, input int kw, input int kh,
                            input logic [7:0] v0, input int i0,
                            input logic [7:0] v1, input int i1);
        for (int ky = 0; ky < kh; ky++) begin
            for (int ox = 0; ox < 2 * kw; ox++) begin
                int pc;
                int kx;
                logic [7:0] e;
                pc = ox / kw;
                kx = ox % kw;
                if (pc == 0) e = (i0 == ky * kw + kx) ? v0 : 8'd0;
                else e = (i1 == ky * kw + kx) ? v1 : 8'd0;
                if (to3) q3.push_back(e);
                else q0.push_back(e);
            end
        end
    endtask

    // Present one element and hold it until taken; waits counts refused cycles.
    task automatic send0(input logic [7:0] v, input logic [1:0] idx, output int waits);
        bit done;
        waits = 0;
        done  = 1'b0;
        bus0.data_in_0       = v;
        bus0.data_in_0_index = idx;
        bus0.data_in_0_valid = 1'b1;
        while (!done) begin
            @(negedge clk);
            if (bus0.data_in_0_ready) done = 1'b1;
            else begin
                waits++;
                if (waits > 100) begin
                    check("dut0 accept timeout", 32'd0, 32'd1);
                    done = 1'b1;
                end
            end
        end
        @(posedge clk);
        #1;
        bus0.data_in_0_valid = 1'b0;
    endtask

    task automatic send3(input logic [7:0] v, input logic [1:0] idx);
        int waits;
        bit done;
        waits = 0;
        done  = 1'b0;
        bus3.data_in_0       = v;
        bus3.data_in_0_index = idx;
        bus3.data_in_0_valid = 1'b1;
        while (!done) begin
            @(negedge clk);
            if (bus3.data_in_0_ready) done = 1'b1;
            else begin
                waits++;
                if (waits > 100) begin
                    check("dut3 accept timeout", 32'd0, 32'd1);
                    done = 1'b1;
                end
            end
        end
        @(posedge clk);
        #1;
        bus3.data_in_0_valid = 1'b0;
    endtask

    task automatic row0(input logic [7:0] v0, input int i0, input logic [7:0] v1, input int i1);
        int w;
        push_row(1'b0, 2, 2, v0, i0, v1, i1);
        send0(v0, 2'(i0), w);
        send0(v1, 2'(i1), w);
    endtask

    task automatic row3(input logic [7:0] v0, input int i0, input logic [7:0] v1, input int i1);
        push_row(1'b1, 3, 1, v0, i0, v1, i1);
        send3(v0, 2'(i0));
        send3(v1, 2'(i1));
    endtask

    task automatic wait_outs0(input int target);
        int n;
        n = 0;
        while (outs0 < target && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (outs0 < target) check("dut0 output timeout", 32'(outs0), 32'(target));
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((q0.size() != 0 || q3.size() != 0) && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain queues empty", 32'(q0.size() + q3.size()), 32'd0);
    endtask

    initial begin
        int base;
        int w;
        rst = 1'b1;
        bus0.data_in_0 = '0; bus0.data_in_0_index = '0; bus0.data_in_0_valid = 1'b0;
        bus0.data_out_0_ready = 1'b1;
        bus3.data_in_0 = '0; bus3.data_in_0_index = '0; bus3.data_in_0_valid = 1'b0;
        bus3.data_out_0_ready = 1'b1;

        // Reset state, with valid offered so ready is genuinely tested.
        bus0.data_in_0_valid = 1'b1;
        repeat (2) @(negedge clk);
        check("rst ready low", 32'(bus0.data_in_0_ready), 32'd0);
        check("rst valid low", 32'(bus0.data_out_0_valid), 32'd0);
        check("rst data zero", 32'(bus0.data_out_0), 32'd0);
        check("rst index_error", 32'(err0), 32'd0);
        bus0.data_in_0_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("ready after rst", 32'(bus0.data_in_0_ready), 32'd1);

        // Row with index 0 and 3; latency, ready drop and return.
        base = outs0;
        row0(8'd5, 0, 8'hFD, 3);
        check("first output valid", 32'(bus0.data_out_0_valid), 32'd1);
        check("first output value", 32'(bus0.data_out_0), 32'd5);
        check("ready low in emit", 32'(bus0.data_in_0_ready), 32'd0);
        wait_outs0(base + 8);
        check("ready back after row", 32'(bus0.data_in_0_ready), 32'd1);
        row0(8'h11, 2, 8'h22, 1);
        wait_drain();

        // Full frame, then the pooled-row counter wraps.
        row0(8'd1, 0, 8'd2, 1);
        row0(8'd3, 2, 8'd4, 3);
        wait_drain();
        check("prow wrap", 32'(u_dut.prow_q), 32'd0);

        // Backpressure for 3 cycles on the 3rd output (value 9).
        base = outs0;
        row0(8'd7, 1, 8'd9, 0);
        wait_outs0(base + 2);
        bus0.data_out_0_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall valid", 32'(bus0.data_out_0_valid), 32'd1);
            check("stall data", 32'(bus0.data_out_0), 32'd9);
            @(posedge clk);
            #1;
        end
        bus0.data_out_0_ready = 1'b1;
        wait_outs0(base + 8);
        wait_drain();
        check("stall output count", 32'(outs0 - base), 32'd8);

        // Valid held high through EMIT: accepted on the first FILL cycle.
        row0(8'h31, 3, 8'h32, 2);
        push_row(1'b0, 2, 2, 8'h33, 2, 8'h44, 0);
        send0(8'h33, 2'd2, w);
        check("held valid wait cycles", 32'(w), 32'd8);
        send0(8'h44, 2'd0, w);
        wait_drain();
        check("dut0 index_error clear", 32'(err0), 32'd0);

        // 3x1 kernel with out-of-range index 3.
        row3(8'h12, 3, 8'h34, 1);
        row3(8'h56, 0, 8'h78, 2);
        wait_drain();
        check("dut3 index_error set", 32'(err3), 32'd1);
        row3(8'h9A, 2, 8'hBC, 0);
        row3(8'h01, 1, 8'h02, 2);
        wait_drain();
        check("dut3 index_error sticky", 32'(err3), 32'd1);
        check("dut3 output count", 32'(outs3), 32'd24);

        // Reset after 3 outputs of a row; partial row is discarded.
        base = outs0;
        row0(8'h55, 0, 8'h66, 1);
        wait_outs0(base + 3);
        rst = 1'b1;
        #1;
        check("mid rst valid low", 32'(bus0.data_out_0_valid), 32'd0);
        check("mid rst ready low", 32'(bus0.data_in_0_ready), 32'd0);
        q0.delete();
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        check("ready after mid rst", 32'(bus0.data_in_0_ready), 32'd1);
        check("prow cleared", 32'(u_dut.prow_q), 32'd0);
        check("dut3 index_error cleared", 32'(err3), 32'd0);
        base = outs0;
        row0(8'h77, 3, 8'h88, 2);
        wait_drain();
        check("fresh row count", 32'(outs0 - base), 32'd8);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
